cache_mem_arbiter: RTL and testbench

//  Shares one line-wide memory port (AXI bridge, cache-side bus protocol) between ICache refill and DCache refill/writeback.

---
 rtl/cache_mem_arbiter_pkg.sv | 44 ++++
 rtl/cache_mem_arbiter_if.sv | 67 ++++++
 rtl/mem_rr_arb2.sv | 37 +++
 rtl/cache_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache/memory definitions: line geometry, FSM state types, owner
// encoding and line-address helpers used by the memory-port arbiter.
package cache_mem_arbiter_pkg;

    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LINE_W     = LINE_WORDS * 32;
    localparam int unsigned LINE_OFF_W = $clog2(LINE_WORDS * 4);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_WAIT
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_WAIT
    } wr_state_t;

    // Bit position of each cache in the arbiter request/grant vectors
    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    // Latched writeback payload (line-aligned address + full line)
    typedef struct packed {
        addr_t addr;
        line_t data;
    } wr_req_t;

    localparam addr_t OFF_MASK = addr_t'((64'd1 << LINE_OFF_W) - 64'd1);

    // Clear the byte-offset bits so the address names a whole line
    function automatic addr_t line_align(input addr_t a);
        return a & ~OFF_MASK;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two cache clients, the arbiter and the AXI bridge.
// The arbiter uses the slave view; the caches/bridge side uses master.
interface cache_mem_arbiter_if;
    import cache_mem_arbiter_pkg::*;

    // icache refill
    logic  ic_rd_req;
    addr_t ic_rd_addr;
    logic  ic_rd_rdy;
    logic  ic_ret_valid;
    line_t ic_ret_data;

    // dcache refill
    logic  dc_rd_req;
    addr_t dc_rd_addr;
    logic  dc_rd_rdy;
    logic  dc_ret_valid;
    line_t dc_ret_data;

    // dcache writeback
    logic  dc_wr_req;
    addr_t dc_wr_addr;
    line_t dc_wr_data;
    logic  dc_wr_rdy;
    logic  dc_wr_valid;

    // bridge read channel
    logic  mem_rd_req;
    addr_t mem_rd_addr;
    logic  mem_rd_rdy;
    logic  mem_ret_valid;
    line_t mem_ret_data;

    // bridge write channel
    logic  mem_wr_req;
    addr_t mem_wr_addr;
    line_t mem_wr_data;
    logic  mem_wr_rdy;
    logic  mem_wr_valid;

    modport slave (
        input  ic_rd_req, ic_rd_addr,
        input  dc_rd_req, dc_rd_addr,
        input  dc_wr_req, dc_wr_addr, dc_wr_data,
        input  mem_rd_rdy, mem_ret_valid, mem_ret_data,
        input  mem_wr_rdy, mem_wr_valid,
        output ic_rd_rdy, ic_ret_valid, ic_ret_data,
        output dc_rd_rdy, dc_ret_valid, dc_ret_data,
        output dc_wr_rdy, dc_wr_valid,
        output mem_rd_req, mem_rd_addr,
        output mem_wr_req, mem_wr_addr, mem_wr_data
    );

    modport master (
        output ic_rd_req, ic_rd_addr,
        output dc_rd_req, dc_rd_addr,
        output dc_wr_req, dc_wr_addr, dc_wr_data,
        output mem_rd_rdy, mem_ret_valid, mem_ret_data,
        output mem_wr_rdy, mem_wr_valid,
        input  ic_rd_rdy, ic_ret_valid, ic_ret_data,
        input  dc_rd_rdy, dc_ret_valid, dc_ret_data,
        input  dc_wr_rdy, dc_wr_valid,
        input  mem_rd_req, mem_rd_addr,
        input  mem_wr_req, mem_wr_addr, mem_wr_data
    );

endinterface

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin arbiter. Requests arrive already masked for
// eligibility; bit 0 is the icache, bit 1 the dcache. Grant is one-hot and
// combinational; the pointer remembers the last winner.
module mem_rr_arb2
    import cache_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt_c
);

    owner_t r_last;

    // Sole requester wins; on a tie the side not granted last wins
    always_comb begin
        o_gnt_c = 2'b00;
        if (i_en) begin
            if (i_req[0] && i_req[1]) begin
                o_gnt_c = (r_last == OWN_DC) ? 2'b01 : 2'b10;
            end else begin
                o_gnt_c = i_req;
            end
        end
    end

    // Pointer follows every grant; reset value lets the dcache win the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= OWN_IC;
        end else if (|o_gnt_c) begin
            r_last <= o_gnt_c[1] ? OWN_DC : OWN_IC;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single line-wide bridge port between icache refill and dcache
// refill/writeback. Read and write channels run independent FSMs with one
// outstanding transaction each; reads never overtake a same-line writeback.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    cache_mem_arbiter_if.slave  bus
);

    rd_state_t  r_rd_state;
    rd_state_t  w_rd_state_nxt;
    wr_state_t  r_wr_state;
    wr_state_t  w_wr_state_nxt;

    owner_t     r_rd_owner;
    addr_t      r_rd_addr;
    wr_req_t    r_wr;

    logic       r_ic_rd_rdy;
    logic       r_dc_rd_rdy;
    logic       r_dc_wr_rdy;
    logic       r_mem_rd_req;
    logic       r_mem_wr_req;

    logic       w_hz_active;
    addr_t      w_hz_line;
    logic       w_ic_elig;
    logic       w_dc_elig;
    logic [1:0] w_gnt;
    logic       w_rd_take;
    logic       w_ret_fire;
    logic       w_wr_take;
    logic       w_wr_fire;
    logic       w_ic_ret_c;
    logic       w_dc_ret_c;

    // A read of the line being written back (or about to be accepted) waits
    always_comb begin
        w_hz_active = (r_wr_state != W_IDLE) || bus.dc_wr_req;
        w_hz_line   = (r_wr_state != W_IDLE) ? r_wr.addr : line_align(bus.dc_wr_addr);
        w_ic_elig   = bus.ic_rd_req &&
                      !(w_hz_active && (line_align(bus.ic_rd_addr) == w_hz_line));
        w_dc_elig   = bus.dc_rd_req &&
                      !(w_hz_active && (line_align(bus.dc_rd_addr) == w_hz_line));
    end

    mem_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   ({w_dc_elig, w_ic_elig}),
        .i_en    (r_rd_state == R_IDLE),
        .o_gnt_c (w_gnt)
    );

    // ---------------------------------------------------------------- read

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    // Read FSM next state and transition strobes
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_take      = 1'b0;
        w_ret_fire     = 1'b0;
        unique case (r_rd_state)
            R_IDLE: begin
                if (|w_gnt) begin
                    w_rd_take      = 1'b1;
                    w_rd_state_nxt = R_REQ;
                end
            end
            R_REQ: begin
                if (bus.mem_rd_rdy) begin
                    w_rd_state_nxt = R_WAIT;
                end
            end
            R_WAIT: begin
                if (bus.mem_ret_valid) begin
                    w_ret_fire     = 1'b1;
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    // Read datapath: owner/address latch, accept pulses, bridge request flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_owner   <= OWN_DC;
            r_rd_addr    <= '0;
            r_ic_rd_rdy  <= 1'b0;
            r_dc_rd_rdy  <= 1'b0;
            r_mem_rd_req <= 1'b0;
        end else begin
            r_ic_rd_rdy  <= w_rd_take && w_gnt[0];
            r_dc_rd_rdy  <= w_rd_take && w_gnt[1];
            r_mem_rd_req <= (w_rd_state_nxt == R_REQ);
            if (w_rd_take) begin
                r_rd_owner <= w_gnt[1] ? OWN_DC : OWN_IC;
                r_rd_addr  <= line_align(w_gnt[1] ? bus.dc_rd_addr : bus.ic_rd_addr);
            end
        end
    end

    // Return pulses go straight to the owner in the bridge's completion cycle
    always_comb begin
        w_ic_ret_c = w_ret_fire && (r_rd_owner == OWN_IC);
        w_dc_ret_c = w_ret_fire && (r_rd_owner == OWN_DC);
    end

    // --------------------------------------------------------------- write

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    // Write FSM next state and transition strobes
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_take      = 1'b0;
        w_wr_fire      = 1'b0;
        unique case (r_wr_state)
            W_IDLE: begin
                if (bus.dc_wr_req) begin
                    w_wr_take      = 1'b1;
                    w_wr_state_nxt = W_REQ;
                end
            end
            W_REQ: begin
                if (bus.mem_wr_rdy) begin
                    w_wr_state_nxt = W_WAIT;
                end
            end
            W_WAIT: begin
                if (bus.mem_wr_valid) begin
                    w_wr_fire      = 1'b1;
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    // Write datapath: payload latch, accept pulse, bridge request flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr         <= '0;
            r_dc_wr_rdy  <= 1'b0;
            r_mem_wr_req <= 1'b0;
        end else begin
            r_dc_wr_rdy  <= w_wr_take;
            r_mem_wr_req <= (w_wr_state_nxt == W_REQ);
            if (w_wr_take) begin
                r_wr <= '{addr: line_align(bus.dc_wr_addr), data: bus.dc_wr_data};
            end
        end
    end

    // ------------------------------------------------------------- outputs

    assign bus.ic_rd_rdy    = r_ic_rd_rdy;
    assign bus.dc_rd_rdy    = r_dc_rd_rdy;
    assign bus.ic_ret_valid = w_ic_ret_c;
    assign bus.dc_ret_valid = w_dc_ret_c;
    assign bus.ic_ret_data  = w_ic_ret_c ? bus.mem_ret_data : '0;
    assign bus.dc_ret_data  = w_dc_ret_c ? bus.mem_ret_data : '0;
    assign bus.mem_rd_req   = r_mem_rd_req;
    assign bus.mem_rd_addr  = r_rd_addr;

    assign bus.dc_wr_rdy    = r_dc_wr_rdy;
    assign bus.dc_wr_valid  = w_wr_fire;
    assign bus.mem_wr_req   = r_mem_wr_req;
    assign bus.mem_wr_addr  = r_wr.addr;
    assign bus.mem_wr_data  = r_wr.data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed client/bridge sequences with a
// return-order scoreboard checked by a monitor on every completion pulse.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    typedef struct {
        owner_t own;
        line_t  data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cache_mem_arbiter_if ifc ();

    cache_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int      n_chk = 0;
    int      n_err = 0;
    rd_exp_t exp_q[$];
    int      wr_q[$];
    rd_exp_t mon_e;
    addr_t   got_addr;

    // Count one comparison and report it when observed differs from expected
    task automatic chk(input string tag, input line_t got, input line_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected line for a line address; line 0x1230 returns all 0xA5 bytes
    function automatic line_t line_of(input addr_t a);
        return {4{32'hA5A5_A5A5 ^ a ^ 32'h0000_1230}};
    endfunction

    function automatic addr_t align16(input addr_t a);
        return a & 32'hFFFF_FFF0;
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        wr_q.delete();
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    // Read client: hold req/addr until rdy, drop it the cycle after
    task automatic client_rd(input bit is_dc, input addr_t a);
        bit seen = 1'b0;
        if (is_dc) begin ifc.dc_rd_req = 1'b1; ifc.dc_rd_addr = a; end
        else       begin ifc.ic_rd_req = 1'b1; ifc.ic_rd_addr = a; end
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = is_dc ? ifc.dc_rd_rdy : ifc.ic_rd_rdy;
        end
        chk("rd_rdy_timeout", line_t'(seen), line_t'(1));
        nxt();
        if (is_dc) ifc.dc_rd_req = 1'b0;
        else       ifc.ic_rd_req = 1'b0;
    endtask

    // Writeback client
    task automatic client_wr(input addr_t a, input line_t d);
        bit seen = 1'b0;
        ifc.dc_wr_req  = 1'b1;
        ifc.dc_wr_addr = a;
        ifc.dc_wr_data = d;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = ifc.dc_wr_rdy;
        end
        chk("wr_rdy_timeout", line_t'(seen), line_t'(1));
        nxt();
        ifc.dc_wr_req = 1'b0;
    endtask

    // Bridge: wait for a read request, check it, accept it; ends in R_WAIT
    task automatic rd_accept(input addr_t exp_addr, output addr_t got);
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = ifc.mem_rd_req;
        end
        chk("mem_rd_req_timeout", line_t'(seen), line_t'(1));
        chk("mem_rd_addr", line_t'(ifc.mem_rd_addr), line_t'(exp_addr));
        got = ifc.mem_rd_addr;
        nxt();
        ifc.mem_rd_rdy = 1'b1;
        nxt();
        ifc.mem_rd_rdy = 1'b0;
    endtask

    task automatic rd_return(input addr_t a);
        ifc.mem_ret_valid = 1'b1;
        ifc.mem_ret_data  = line_of(a);
        nxt();
        ifc.mem_ret_valid = 1'b0;
        ifc.mem_ret_data  = '0;
    endtask

    task automatic serve_read(input addr_t exp_addr);
        addr_t a;
        rd_accept(exp_addr, a);
        rd_return(a);
    endtask

    // Bridge: wait for a write request, check it, accept it; ends in W_WAIT
    task automatic wr_accept(input addr_t exp_addr, input line_t exp_data);
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = ifc.mem_wr_req;
        end
        chk("mem_wr_req_timeout", line_t'(seen), line_t'(1));
        chk("mem_wr_addr", line_t'(ifc.mem_wr_addr), line_t'(exp_addr));
        chk("mem_wr_data", ifc.mem_wr_data, exp_data);
        nxt();
        ifc.mem_wr_rdy = 1'b1;
        nxt();
        ifc.mem_wr_rdy = 1'b0;
    endtask

    // Scoreboard monitor: every completion pulse must match the next expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.ic_ret_valid || ifc.dc_ret_valid) begin
                chk("ret_both", line_t'(ifc.ic_ret_valid && ifc.dc_ret_valid), line_t'(0));
                if (exp_q.size() == 0) begin
                    chk("ret_unexpected", line_t'(ifc.ic_ret_valid || ifc.dc_ret_valid), line_t'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ret_owner", line_t'(ifc.dc_ret_valid), line_t'(mon_e.own == OWN_DC));
                    chk("ret_data", ifc.dc_ret_valid ? ifc.dc_ret_data : ifc.ic_ret_data, mon_e.data);
                end
            end
            if (ifc.dc_wr_valid) begin
                if (wr_q.size() == 0) chk("wr_unexpected", line_t'(ifc.dc_wr_valid), line_t'(0));
                else void'(wr_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        ifc.ic_rd_req     = 1'b0;
        ifc.ic_rd_addr    = '0;
        ifc.dc_rd_req     = 1'b0;
        ifc.dc_rd_addr    = '0;
        ifc.dc_wr_req     = 1'b0;
        ifc.dc_wr_addr    = '0;
        ifc.dc_wr_data    = '0;
        ifc.mem_rd_rdy    = 1'b0;
        ifc.mem_ret_valid = 1'b0;
        ifc.mem_ret_data  = '0;
        ifc.mem_wr_rdy    = 1'b0;
        ifc.mem_wr_valid  = 1'b0;

        // Reset state
        nxt();
        nxt();
        @(negedge clk);
        chk("rst_mem_rd_req", line_t'(ifc.mem_rd_req), line_t'(0));
        chk("rst_mem_wr_req", line_t'(ifc.mem_wr_req), line_t'(0));
        chk("rst_rdy", line_t'({ifc.ic_rd_rdy, ifc.dc_rd_rdy, ifc.dc_wr_rdy}), line_t'(0));
        chk("rst_valid", line_t'({ifc.ic_ret_valid, ifc.dc_ret_valid, ifc.dc_wr_valid}), line_t'(0));
        chk("rst_mem_rd_addr", line_t'(ifc.mem_rd_addr), line_t'(0));
        nxt();
        rst = 1'b0;

        // Single dcache refill with exact cycle timing
        ifc.dc_rd_req  = 1'b1;
        ifc.dc_rd_addr = 32'h0000_1234;
        exp_q.push_back('{OWN_DC, line_of(32'h0000_1230)});
        @(negedge clk);
        chk("t1_rdy_T0", line_t'(ifc.dc_rd_rdy), line_t'(0));
        nxt();
        @(negedge clk);
        chk("t1_dc_rdy_T1", line_t'(ifc.dc_rd_rdy), line_t'(1));
        chk("t1_ic_rdy_T1", line_t'(ifc.ic_rd_rdy), line_t'(0));
        chk("t1_mem_req_T1", line_t'(ifc.mem_rd_req), line_t'(1));
        chk("t1_mem_addr_T1", line_t'(ifc.mem_rd_addr), line_t'(32'h0000_1230));
        nxt();
        ifc.dc_rd_req  = 1'b0;
        ifc.mem_rd_rdy = 1'b1;
        @(negedge clk);
        chk("t1_mem_req_T2", line_t'(ifc.mem_rd_req), line_t'(1));
        chk("t1_dc_rdy_T2", line_t'(ifc.dc_rd_rdy), line_t'(0));
        nxt();
        ifc.mem_rd_rdy = 1'b0;
        @(negedge clk);
        chk("t1_mem_req_T3", line_t'(ifc.mem_rd_req), line_t'(0));
        chk("t1_ret_T3", line_t'(ifc.dc_ret_valid), line_t'(0));
        nxt();
        ifc.mem_ret_valid = 1'b1;
        ifc.mem_ret_data  = line_of(ifc.mem_rd_addr);
        @(negedge clk);
        chk("t1_dc_ret_T4", line_t'(ifc.dc_ret_valid), line_t'(1));
        chk("t1_ic_ret_T4", line_t'(ifc.ic_ret_valid), line_t'(0));
        chk("t1_dc_data_T4", ifc.dc_ret_data, {4{32'hA5A5_A5A5}});
        nxt();
        ifc.mem_ret_valid = 1'b0;
        ifc.mem_ret_data  = '0;
        @(negedge clk);
        chk("t1_ret_T5", line_t'(ifc.dc_ret_valid), line_t'(0));

        // Simultaneous requests after reset: dcache first, twice in a row
        do_reset();
        for (int p = 0; p < 2; p++) begin
            addr_t ia = 32'h2000_0010 + addr_t'(p) * 32'h100;
            addr_t da = 32'h3000_0024 + addr_t'(p) * 32'h100;
            exp_q.push_back('{OWN_DC, line_of(align16(da))});
            exp_q.push_back('{OWN_IC, line_of(align16(ia))});
            fork
                client_rd(1'b0, ia);
                client_rd(1'b1, da);
                begin
                    serve_read(align16(da));
                    serve_read(align16(ia));
                end
            join
        end

        // Same-line read held behind a writeback in W_WAIT; icache proceeds
        fork
            client_wr(32'h8000_0040, {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000});
            wr_accept(32'h8000_0040, {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000});
        join
        exp_q.push_back('{OWN_IC, line_of(32'h1FC0_0000)});
        exp_q.push_back('{OWN_DC, line_of(32'h8000_0040)});
        fork
            client_rd(1'b1, 32'h8000_0048);
            client_rd(1'b0, 32'h1FC0_0000);
            begin
                serve_read(32'h1FC0_0000);
                repeat (3) begin
                    @(negedge clk);
                    chk("raw_hold_rdy", line_t'(ifc.dc_rd_rdy), line_t'(0));
                    chk("raw_hold_req", line_t'(ifc.mem_rd_req), line_t'(0));
                end
                nxt();
                ifc.mem_wr_valid = 1'b1;
                wr_q.push_back(1);
                @(negedge clk);
                chk("raw_wr_valid", line_t'(ifc.dc_wr_valid), line_t'(1));
                nxt();
                ifc.mem_wr_valid = 1'b0;
                serve_read(32'h8000_0040);
            end
        join

        // Read and write complete in the same cycle
        fork
            client_wr(32'h5000_0080, {4{32'h0BAD_F00D}});
            wr_accept(32'h5000_0080, {4{32'h0BAD_F00D}});
        join
        exp_q.push_back('{OWN_DC, line_of(32'h4000_0000)});
        fork
            client_rd(1'b1, 32'h4000_000C);
            rd_accept(32'h4000_0000, got_addr);
        join
        ifc.mem_ret_valid = 1'b1;
        ifc.mem_ret_data  = line_of(got_addr);
        ifc.mem_wr_valid  = 1'b1;
        wr_q.push_back(1);
        @(negedge clk);
        chk("both_dc_ret", line_t'(ifc.dc_ret_valid), line_t'(1));
        chk("both_dc_wr", line_t'(ifc.dc_wr_valid), line_t'(1));
        nxt();
        ifc.mem_ret_valid = 1'b0;
        ifc.mem_wr_valid  = 1'b0;

        // Reset in R_WAIT cancels the refill; late and idle responses are ignored
        exp_q.push_back('{OWN_DC, line_of(32'h6000_0000)});
        fork
            client_rd(1'b1, 32'h6000_0004);
            rd_accept(32'h6000_0000, got_addr);
        join
        rst = 1'b1;
        exp_q.delete();
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("rw_rst_mem_req", line_t'(ifc.mem_rd_req), line_t'(0));
        chk("rw_rst_addr", line_t'(ifc.mem_rd_addr), line_t'(0));
        chk("rw_rst_rdy", line_t'({ifc.ic_rd_rdy, ifc.dc_rd_rdy, ifc.dc_wr_rdy}), line_t'(0));
        chk("rw_rst_ret", line_t'({ifc.ic_ret_valid, ifc.dc_ret_valid}), line_t'(0));
        nxt();
        ifc.mem_ret_valid = 1'b1;
        ifc.mem_ret_data  = line_of(got_addr);
        ifc.mem_wr_valid  = 1'b1;
        @(negedge clk);
        chk("stray_dc_ret", line_t'(ifc.dc_ret_valid), line_t'(0));
        chk("stray_ic_ret", line_t'(ifc.ic_ret_valid), line_t'(0));
        chk("stray_wr_valid", line_t'(ifc.dc_wr_valid), line_t'(0));
        nxt();
        ifc.mem_ret_valid = 1'b0;
        ifc.mem_ret_data  = '0;
        ifc.mem_wr_valid  = 1'b0;

        repeat (3) nxt();
        chk("rd_q_drained", line_t'(exp_q.size()), line_t'(0));
        chk("wr_q_drained", line_t'(wr_q.size()), line_t'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
